// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two byte requesters, the arbiter and the FIFO write port.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int B = 8
);
    logic         req0;
    logic [B-1:0] data0;
    logic         last0;
    logic         ack0;
    logic         req1;
    logic [B-1:0] data1;
    logic         last1;
    logic         ack1;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;
    logic [1:0]   owner;
    logic         len_err;

    modport slave (
        input  req0, data0, last0, req1, data1, last1, fifo_full,
        output ack0, ack1, fifo_wr, fifo_w_data, owner, len_err
    );

    modport master (
        output req0, data0, last0, req1, data1, last1, fifo_full,
        input  ack0, ack1, fifo_wr, fifo_w_data, owner, len_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Message-atomic round-robin arbiter for the UART TX FIFO write port: one requester owns the
// port for a whole message (or MAX_LEN bytes), then ownership is re-arbitrated from IDLE.
module fifo_wr_arbiter #(
    parameter int B       = 8,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_LEN - 1);

    state_t       state_r, state_s;
    logic         last_owner_r, last_owner_s;
    logic [7:0]   cnt_r, cnt_s;
    logic         len_err_r, len_err_s;
    logic         sel_req_s, sel_last_s, sel_id_s;
    logic         wr_s, ack0_s, ack1_s;
    logic [B-1:0] w_data_s;

    // Next-state, counter and write-port decode
    always_comb begin
        state_s      = state_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        len_err_s    = 1'b0;
        sel_req_s    = 1'b0;
        sel_last_s   = 1'b0;
        sel_id_s     = 1'b0;
        wr_s         = 1'b0;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        w_data_s     = {B{1'b0}};
        case (state_r)
            IDLE: begin
                // On a tie the requester that did not own the port last time wins.
                if (bus.req0 && bus.req1) begin
                    state_s = last_owner_r ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_s = OWN0;
                end else if (bus.req1) begin
                    state_s = OWN1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0: begin
                sel_req_s  = bus.req0;
                sel_last_s = bus.last0;
                sel_id_s   = 1'b0;
                w_data_s   = bus.data0;
            end
            OWN1: begin
                sel_req_s  = bus.req1;
                sel_last_s = bus.last1;
                sel_id_s   = 1'b1;
                w_data_s   = bus.data1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Acceptance is masked during reset so a mid-message reset never acks a byte.
        if (sel_req_s && !bus.fifo_full && !reset) begin
            wr_s   = 1'b1;
            ack0_s = ~sel_id_s;
            ack1_s = sel_id_s;
            if (sel_last_s || (cnt_r == CNT_LAST)) begin
                state_s      = IDLE;
                last_owner_s = sel_id_s;
                cnt_s        = 8'd0;
                len_err_s    = ~sel_last_s;
            end else begin
                cnt_s = cnt_r + 8'd1;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, round-robin history, byte counter and truncation flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            cnt_r        <= 8'd0;
            len_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            len_err_r    <= len_err_s;
        end
    end

    assign bus.fifo_wr     = wr_s;
    assign bus.ack0        = ack0_s;
    assign bus.ack1        = ack1_s;
    assign bus.fifo_w_data = w_data_s;
    assign bus.owner       = state_r;
    assign bus.len_err     = len_err_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a message-level model.
module tb_fifo_wr_arbiter;
    localparam int B    = 8;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.B(B)) bus();

    fifo_wr_arbiter #(.B(B), .MAX_LEN(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       l;
        logic [7:0] d;
    } byte_t;

    byte_t q0[$];
    byte_t q1[$];
    int    checks   = 0;
    int    failures = 0;
    bit    rand_mode = 1'b0;
    bit    full_cmd  = 1'b0;
    bit    chk_en    = 1'b0;
    int    own_log[$], wr_log[$], ack_log[$], le_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_seq(input string name, input int got[$], input int exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic msg(input int who, input int first, input int n, input bit last_on_end);
        byte_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 8'(first + i);
            b.l = last_on_end && (i == n - 1);
            if (who == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic clear_logs();
        own_log.delete(); wr_log.delete(); ack_log.delete(); le_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Requester/FIFO driver: presents queue heads, pops on ack
    initial begin
        bus.req0 = 1'b0; bus.data0 = 8'h00; bus.last0 = 1'b0;
        bus.req1 = 1'b0; bus.data1 = 8'h00; bus.last1 = 1'b0;
        bus.fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.req0 = (q0.size() > 0) && (!rand_mode || ($urandom_range(0, 4) != 0));
            bus.req1 = (q1.size() > 0) && (!rand_mode || ($urandom_range(0, 4) != 0));
            if (q0.size() > 0) begin bus.data0 = q0[0].d; bus.last0 = q0[0].l; end
            else begin bus.data0 = 8'($urandom); bus.last0 = 1'($urandom); end
            if (q1.size() > 0) begin bus.data1 = q1[0].d; bus.last1 = q1[0].l; end
            else begin bus.data1 = 8'($urandom); bus.last1 = 1'($urandom); end
            bus.fifo_full = rand_mode ? ($urandom_range(0, 3) == 0) : full_cmd;
            @(negedge clk);
            if (bus.ack0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
            if (bus.ack1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
        end
    end

    // Reference model (owner -1 = nobody) and per-cycle compare
    initial begin
        int om;
        bit lm;
        int cm;
        bit lem;
        bit acc;
        bit lst;
        int eo;
        logic [7:0] ed;
        om = -1; lm = 1'b1; cm = 0; lem = 1'b0;
        forever begin
            @(negedge clk);
            eo  = (om < 0) ? 0 : ((om == 0) ? 1 : 2);
            acc = !reset && (om >= 0) && ((om == 0) ? bus.req0 : bus.req1) && !bus.fifo_full;
            ed  = (om == 0) ? bus.data0 : ((om == 1) ? bus.data1 : 8'h00);
            if (chk_en) begin
                check("owner",       bus.owner,       eo);
                check("fifo_wr",     bus.fifo_wr,     acc);
                check("ack0",        bus.ack0,        acc && (om == 0));
                check("ack1",        bus.ack1,        acc && (om == 1));
                check("len_err",     bus.len_err,     lem);
                check("fifo_w_data", bus.fifo_w_data, ed);
            end
            own_log.push_back(int'(bus.owner));
            wr_log.push_back((bus.fifo_wr === 1'b1) ? int'(bus.fifo_w_data) : -1);
            ack_log.push_back(int'({bus.ack1, bus.ack0}));
            le_log.push_back(int'(bus.len_err));
            if (reset) begin
                om = -1; lm = 1'b1; cm = 0; lem = 1'b0;
            end else begin
                lem = 1'b0;
                if (om < 0) begin
                    if (bus.req0 && bus.req1) om = lm ? 0 : 1;
                    else if (bus.req0)        om = 0;
                    else if (bus.req1)        om = 1;
                end else if (acc) begin
                    lst = (om == 0) ? bus.last0 : bus.last1;
                    cm++;
                    if (lst || cm == MAXL) begin
                        lem = !lst;
                        lm  = (om == 1);
                        om  = -1;
                        cm  = 0;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Single message
        clear_logs();
        msg(0, 'h41, 3, 1'b1);
        repeat (5) @(negedge clk);
        tick();
        cmp_seq("t1_owner", own_log, '{0, 1, 1, 1, 0});
        cmp_seq("t1_wr",    wr_log,  '{-1, 'h41, 'h42, 'h43, -1});

        // Tie after reset
        do_reset();
        clear_logs();
        msg(0, 'h10, 2, 1'b1);
        msg(1, 'h20, 2, 1'b1);
        repeat (7) @(negedge clk);
        tick();
        cmp_seq("t2_owner", own_log, '{0, 1, 1, 0, 2, 2, 0});
        cmp_seq("t2_wr",    wr_log,  '{-1, 'h10, 'h11, -1, 'h20, 'h21, -1});

        // Round-robin of one-byte messages
        clear_logs();
        msg(0, 'h30, 1, 1'b1); msg(0, 'h31, 1, 1'b1);
        msg(1, 'h50, 1, 1'b1); msg(1, 'h51, 1, 1'b1);
        repeat (9) @(negedge clk);
        tick();
        cmp_seq("t3_owner", own_log, '{0, 1, 0, 2, 0, 1, 0, 2, 0});
        cmp_seq("t3_ack",   ack_log, '{0, 1, 0, 2, 0, 1, 0, 2, 0});
        cmp_seq("t3_wr",    wr_log,  '{-1, 'h30, -1, 'h50, -1, 'h31, -1, 'h51, -1});

        // Backpressure during an OWN1 message
        clear_logs();
        msg(1, 'h60, 3, 1'b1);
        repeat (2) @(negedge clk);
        tick();
        full_cmd = 1'b1;
        repeat (3) tick();
        full_cmd = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        cmp_seq("t4_owner", own_log, '{0, 2, 2, 2, 2, 2, 2, 0});
        cmp_seq("t4_wr",    wr_log,  '{-1, 'h60, -1, -1, -1, 'h61, 'h62, -1});
        cmp_seq("t4_ack",   ack_log, '{0, 2, 0, 0, 0, 2, 2, 0});

        // Length limit truncation
        clear_logs();
        msg(0, 'h70, 6, 1'b0);
        repeat (9) @(negedge clk);
        tick();
        cmp_seq("t5_owner", own_log, '{0, 1, 1, 1, 1, 0, 1, 1, 1});
        cmp_seq("t5_wr",    wr_log,  '{-1, 'h70, 'h71, 'h72, 'h73, -1, 'h74, 'h75, -1});
        cmp_seq("t5_lenerr", le_log, '{0, 0, 0, 0, 0, 1, 0, 0, 0});

        // Reset mid-message, then a tie must go to requester 0 again
        do_reset();
        clear_logs();
        msg(0, 'h88, 1, 1'b1);
        msg(0, 'h80, 5, 1'b1);
        repeat (5) @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        msg(0, 'h90, 1, 1'b1);
        msg(1, 'hA0, 1, 1'b1);
        repeat (5) @(negedge clk);
        tick();
        cmp_seq("t6_owner",  own_log, '{0, 1, 0, 1, 1, 1, 0, 1, 0, 2, 0});
        cmp_seq("t6_wr",     wr_log,  '{-1, 'h88, -1, 'h80, 'h81, -1, -1, 'h90, -1, 'hA0, -1});
        cmp_seq("t6_ack",    ack_log, '{0, 1, 0, 1, 1, 0, 0, 1, 0, 2, 0});
        cmp_seq("t6_lenerr", le_log,  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        // Randomized traffic with random stalls and gaps
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (q0.size() < 6 && $urandom_range(0, 2) == 0)
                msg(0, $urandom_range(0, 255), $urandom_range(1, 6), 1'b1);
            if (q1.size() < 6 && $urandom_range(0, 2) == 0)
                msg(1, $urandom_range(0, 255), $urandom_range(1, 6), 1'b1);
            tick();
        end
        rand_mode = 1'b0;
        full_cmd  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        check("drain", q0.size() + q1.size(), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
